// File: rtl/lcd_fifo_sched.sv
// lcd_fifo_sched: round-robin cmd/pix arbiter onto the LCD FIFO write port and timed LCD bus writer draining its read port
module lcd_fifo_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int T_SETUP    = 1,
  parameter int T_WR       = 2,
  parameter int T_HOLD     = 1,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_ready,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic [DATA_WIDTH:0]   fifo_wdata,
  output logic                  fifo_winc,
  input  logic                  fifo_wfull,
  input  logic [DATA_WIDTH:0]   fifo_rdata,
  output logic                  fifo_rinc,
  input  logic                  fifo_rempty,
  output logic                  lcd_cs_n,
  output logic                  lcd_wr_n,
  output logic                  lcd_dc,
  output logic [DATA_WIDTH-1:0] lcd_data,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam logic [CNT_WIDTH-1:0] LD_SETUP = CNT_WIDTH'(T_SETUP - 1);
  localparam logic [CNT_WIDTH-1:0] LD_WR    = CNT_WIDTH'(T_WR - 1);
  localparam logic [CNT_WIDTH-1:0] LD_HOLD  = CNT_WIDTH'(T_HOLD - 1);
  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic                  last_pix, cmd_el, pix_el, grant_cmd, grant_pix, dc_n;
  logic [DATA_WIDTH-1:0] data_n;
  assign cmd_el     = cmd_valid & ~fifo_wfull;
  assign pix_el     = pix_valid & ~fifo_wfull;
  assign grant_pix  = pix_el & (~cmd_el | ~last_pix);
  assign grant_cmd  = cmd_el & ~grant_pix;
  assign cmd_ready  = grant_cmd;
  assign pix_ready  = grant_pix;
  assign fifo_winc  = grant_cmd | grant_pix;
  assign fifo_wdata = grant_cmd ? {1'b0, cmd_data} : {1'b1, pix_data};
  assign busy       = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_pix <= 1'b0;
    else if (fifo_winc) last_pix <= grant_pix;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dc_n      = lcd_dc;
    data_n    = lcd_data;
    fifo_rinc = 1'b0;
    case (state)
      IDLE:
        if (!fifo_rempty) begin
          state_n = SETUP;
          cnt_n   = LD_SETUP;
          dc_n    = fifo_rdata[DATA_WIDTH];
          data_n  = fifo_rdata[DATA_WIDTH-1:0];
        end
      SETUP: begin
        state_n = cnt == '0 ? STROBE : SETUP;
        cnt_n   = cnt == '0 ? LD_WR : cnt - 1'b1;
      end
      STROBE: begin
        state_n = cnt == '0 ? HOLD : STROBE;
        cnt_n   = cnt == '0 ? LD_HOLD : cnt - 1'b1;
      end
      HOLD: begin
        state_n   = cnt == '0 ? IDLE : HOLD;
        cnt_n     = cnt == '0 ? cnt : cnt - 1'b1;
        fifo_rinc = cnt == '0 && !fifo_rempty;
      end
      default: state_n = IDLE;
    endcase
  end
  // bus pins are registered from the next state so they switch cleanly on state entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lcd_cs_n <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_dc   <= 1'b0;
      lcd_data <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lcd_cs_n <= state_n == IDLE;
      lcd_wr_n <= state_n != STROBE;
      lcd_dc   <= dc_n;
      lcd_data <= data_n;
    end
endmodule

// File: tb/tb_lcd_fifo_sched.sv
// tb_lcd_fifo_sched: directed checks of arbitration, LCD write timing, backpressure and async reset
module tb_lcd_fifo_sched;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic       cmd_valid = 0, pix_valid = 0, cmd_ready, pix_ready;
  logic [7:0] cmd_data = 0, pix_data = 0;
  logic [8:0] a_wdata, a_rdata;
  logic       a_winc, a_wfull, a_rinc, a_rempty, a_cs_n, a_wr_n, a_dc, a_busy;
  logic [7:0] a_data;
  logic       force_full = 0;
  logic [8:0] mem [0:15];
  logic [3:0] wp, rp;
  logic [4:0] a_count;
  assign a_wfull  = force_full | (a_count == 5'd16);
  assign a_rempty = a_count == 5'd0;
  assign a_rdata  = mem[rp];
  always @(posedge clk or posedge rst)
    if (rst) begin
      wp <= 0; rp <= 0; a_count <= 0;
    end else begin
      if (a_winc) begin mem[wp] <= a_wdata; wp <= wp + 1'b1; end
      if (a_rinc) rp <= rp + 1'b1;
      a_count <= a_count + {4'd0, a_winc} - {4'd0, a_rinc};
    end
  lcd_fifo_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .fifo_wdata(a_wdata), .fifo_winc(a_winc), .fifo_wfull(a_wfull), .fifo_rdata(a_rdata),
    .fifo_rinc(a_rinc), .fifo_rempty(a_rempty), .lcd_cs_n(a_cs_n), .lcd_wr_n(a_wr_n),
    .lcd_dc(a_dc), .lcd_data(a_data), .busy(a_busy));
  logic       b_en = 0, b_rinc, b_rempty, b_cs_n, b_wr_n, b_dc, b_busy, b_cr, b_pr, b_winc;
  logic [8:0] b_rdata, b_wdata;
  logic [7:0] b_data;
  int         b_idx;
  assign b_rempty = !b_en || b_idx >= 3;
  assign b_rdata  = {1'b1, b_idx == 0 ? 8'h11 : b_idx == 1 ? 8'h22 : 8'h33};
  always @(posedge clk or posedge rst)
    if (rst) b_idx <= 0;
    else if (b_rinc) b_idx <= b_idx + 1;
  lcd_fifo_sched #(.T_SETUP(2), .T_WR(3), .T_HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(1'b0), .cmd_data(8'h00), .cmd_ready(b_cr),
    .pix_valid(1'b0), .pix_data(8'h00), .pix_ready(b_pr),
    .fifo_wdata(b_wdata), .fifo_winc(b_winc), .fifo_wfull(1'b0), .fifo_rdata(b_rdata),
    .fifo_rinc(b_rinc), .fifo_rempty(b_rempty), .lcd_cs_n(b_cs_n), .lcd_wr_n(b_wr_n),
    .lcd_dc(b_dc), .lcd_data(b_data), .busy(b_busy));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // passive monitors on the falling edge, away from the active edge
  int         nf = 0, nr = 0, f_t [0:31];
  logic       f_dc [0:31];
  logic [7:0] f_data [0:31];
  logic       prev_cs = 1'b1;
  always @(negedge clk) begin
    if (prev_cs && !a_cs_n) begin
      f_t[nf] = cyc; f_dc[nf] = a_dc; f_data[nf] = a_data; nf++;
    end
    if (a_rinc) nr++;
    prev_cs = a_cs_n;
  end
  int         b_nf = 0, b_bad = 0, b_t [0:3], b_low [0:3];
  logic [7:0] b_cap [0:3];
  logic       b_prev = 1'b1;
  always @(negedge clk) begin
    if (b_prev && !b_cs_n && b_nf < 4) begin
      b_t[b_nf] = cyc; b_cap[b_nf] = b_data; b_low[b_nf] = 0; b_nf++;
    end
    if (!b_cs_n && b_nf > 0) begin
      if (b_data != b_cap[b_nf-1] || !b_dc) b_bad++;
      if (!b_wr_n) b_low[b_nf-1]++;
    end
    b_prev = b_cs_n;
  end
  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  logic exp_cs [0:5] = '{1, 0, 0, 0, 0, 1};
  logic exp_wr [0:5] = '{1, 1, 0, 0, 1, 1};
  logic exp_ri [0:5] = '{0, 0, 0, 0, 1, 0};
  logic       rr_dc [0:3]   = '{1, 0, 1, 0};
  logic [7:0] rr_data [0:3] = '{8'h50, 8'hA1, 8'h52, 8'hA3};
  logic [7:0] bx [0:2]      = '{8'h11, 8'h22, 8'h33};
  int base, rbase;
  bit found;
  initial begin
    tick; tick;
    check("rst_cs_n", a_cs_n, 1); check("rst_wr_n", a_wr_n, 1); check("rst_dc", a_dc, 0);
    check("rst_data", a_data, 0); check("rst_busy", a_busy, 0); check("rst_rinc", a_rinc, 0);
    check("rst_winc", a_winc, 0);
    rst = 0;
    tick;
    cmd_valid = 1; cmd_data = 8'h2C;
    #1;
    check("t1_cmd_ready", cmd_ready, 1); check("t1_pix_ready", pix_ready, 0);
    check("t1_winc", a_winc, 1); check("t1_wdata", a_wdata, 9'h02C);
    tick;
    cmd_valid = 0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t1_cs_n%0d", k), a_cs_n, exp_cs[k]);
      check($sformatf("t1_wr_n%0d", k), a_wr_n, exp_wr[k]);
      check($sformatf("t1_rinc%0d", k), a_rinc, exp_ri[k]);
      check($sformatf("t1_busy%0d", k), a_busy, !exp_cs[k]);
      if (k == 1) begin check("t1_dc", a_dc, 0); check("t1_data", a_data, 8'h2C); end
      tick;
    end
    repeat (3) tick;
    base = nf; rbase = nr;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1; pix_valid = 1; cmd_data = 8'hA0 + 8'(i); pix_data = 8'h50 + 8'(i);
      #1;
      check($sformatf("rr_pix_ready%0d", i), pix_ready, i % 2 == 0);
      check($sformatf("rr_cmd_ready%0d", i), cmd_ready, i % 2 == 1);
      tick;
    end
    cmd_valid = 0; pix_valid = 0;
    for (int c = 0; c < 60 && nf < base + 4; c++) tick;
    repeat (6) tick;
    check("rr_words", nf - base, 4);
    check("rr_pops", nr - rbase, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_dc%0d", i), f_dc[base+i], rr_dc[i]);
      check($sformatf("rr_data%0d", i), f_data[base+i], rr_data[i]);
      if (i > 0) check($sformatf("rr_period%0d", i), f_t[base+i] - f_t[base+i-1], 5);
    end
    pix_valid = 1; pix_data = 8'h77;
    #1;
    check("bp_pre_pix", pix_ready, 1);
    tick;
    force_full = 1; cmd_valid = 1; pix_data = 8'h78; cmd_data = 8'hC0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("bp_cmd_ready%0d", i), cmd_ready, 0);
      check($sformatf("bp_pix_ready%0d", i), pix_ready, 0);
      check($sformatf("bp_winc%0d", i), a_winc, 0);
      tick;
    end
    force_full = 0;
    #1;
    check("bp_rel_cmd", cmd_ready, 1); check("bp_rel_pix", pix_ready, 0);
    check("bp_rel_wdata", a_wdata, 9'h0C0);
    tick;
    check("bp_next_pix", pix_ready, 1); check("bp_next_cmd", cmd_ready, 0);
    tick;
    cmd_valid = 0; pix_valid = 0;
    repeat (20) tick;
    rbase = nr;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("em_cs_n%0d", i), a_cs_n, 1);
      check($sformatf("em_busy%0d", i), a_busy, 0);
      tick;
    end
    check("em_no_pop", nr - rbase, 0);
    cmd_valid = 1; cmd_data = 8'h5A;
    tick;
    cmd_valid = 0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (!a_wr_n) found = 1;
      else tick;
    end
    check("ms_strobe_seen", found, 1);
    rbase = nr;
    #2 rst = 1;
    #1;
    check("ms_wr_n", a_wr_n, 1); check("ms_cs_n", a_cs_n, 1);
    check("ms_busy", a_busy, 0); check("ms_rinc", a_rinc, 0);
    tick;
    rst = 0;
    repeat (4) tick;
    check("ms_no_pop", nr - rbase, 0);
    check("ms_cs_after", a_cs_n, 1);
    b_en = 1;
    for (int c = 0; c < 60 && !(b_nf == 3 && b_idx == 3 && !b_busy); c++) tick;
    check("tp_words", b_nf, 3);
    check("tp_pops", b_idx, 3);
    check("tp_stable", b_bad, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tp_data%0d", i), b_cap[i], bx[i]);
      check($sformatf("tp_wr_low%0d", i), b_low[i], 3);
      if (i > 0) check($sformatf("tp_period%0d", i), b_t[i] - b_t[i-1], 8);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_fifo_sched.md
# lcd_fifo_sched

Controller for the shared LCD write FIFO. It arbitrates two requesters onto the FIFO write port: the command path and the pixel path. Each word is tagged with a data/command bit. It also drains the FIFO read port into timed LCD bus write cycles, with programmable setup, strobe and hold. It sits between the frame/command generators and the LCD pins, and is the only agent that drives the FIFO's `winc` and `rinc`.

## Interface
Parameters:
- `DATA_WIDTH`, 8: LCD bus width. The FIFO is instantiated with `DATASIZE = DATA_WIDTH+1`.
- `T_SETUP`, 1: cycles `lcd_cs_n`/`lcd_dc`/`lcd_data` are valid before `lcd_wr_n` falls (≥1).
- `T_WR`, 2: cycles `lcd_wr_n` stays low (≥1).
- `T_HOLD`, 1: cycles after `lcd_wr_n` rises before the cycle ends (≥1).
- `CNT_WIDTH`, 4: phase counter width. Each `T_*` must be ≤ 2^CNT_WIDTH.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `cmd_valid` in 1: command word offered.
- `cmd_data` in DATA_WIDTH: command word.
- `cmd_ready` out 1: command word accepted this cycle.
- `pix_valid` in 1: pixel word offered.
- `pix_data` in DATA_WIDTH: pixel word.
- `pix_ready` out 1: pixel word accepted this cycle.
- `fifo_wdata` out DATA_WIDTH+1: `{dc, data}`, with dc=0 for command and 1 for pixel.
- `fifo_winc` out 1: FIFO push.
- `fifo_wfull` in 1: FIFO full.
- `fifo_rdata` in DATA_WIDTH+1: FIFO head word (fall-through, combinational).
- `fifo_rinc` out 1: FIFO pop.
- `fifo_rempty` in 1: FIFO empty.
- `lcd_cs_n`, `lcd_wr_n` out 1: chip select and write strobe (active low).
- `lcd_dc` out 1: data/command select.
- `lcd_data` out DATA_WIDTH: bus data.
- `busy` out 1: write-cycle FSM not in IDLE.

## Operation
Write side (combinational grant, one register `last_pix`):
- **Eligibility:** requester X is eligible when `X_valid & ~fifo_wfull`.
- **Single requester:** if only one requester is eligible, it is granted.
- **Both eligible:** round-robin. Grant pix if `last_pix==0`, else cmd.
- **Grant outputs:** `X_ready = grant_X`, `fifo_winc = grant_cmd | grant_pix`. `fifo_wdata` is `{1'b0,cmd_data}` on a cmd grant and `{1'b1,pix_data}` otherwise.
- **Arbiter state:** `last_pix` updates only on a grant (1 for pix, 0 for cmd). It resets to 0, so pix wins the first tie.
- **Never push when full:** `fifo_winc` is never asserted while `fifo_wfull`=1. The FIFO's simultaneous-push/pop path does not check full/empty, so the controller enforces this.

Read side FSM: IDLE → SETUP → STROBE → HOLD → IDLE, driven by a down-counter `cnt`.
- **IDLE:** `lcd_cs_n`=1, `lcd_wr_n`=1. If `~fifo_rempty`, latch `lcd_dc <= fifo_rdata[DATA_WIDTH]` and `lcd_data <= fifo_rdata[DATA_WIDTH-1:0]`, load `cnt <= T_SETUP-1`, and go to SETUP.
- **SETUP:** `lcd_cs_n`=0, `lcd_wr_n`=1. At `cnt==0`, load `T_WR-1` and go to STROBE. Otherwise decrement.
- **STROBE:** `lcd_cs_n`=0, `lcd_wr_n`=0. At `cnt==0`, load `T_HOLD-1` and go to HOLD.
- **HOLD:** `lcd_cs_n`=0, `lcd_wr_n`=1. At `cnt==0`, assert `fifo_rinc` for exactly this one cycle and go to IDLE.
- **Pop safety:** `fifo_rinc` is never asserted while `fifo_rempty`=1. The latched word is still the head, because only this block pops.
- **Output registers:** `lcd_cs_n`, `lcd_wr_n`, `lcd_dc` and `lcd_data` are registered, with no glitches. `lcd_dc`/`lcd_data` are stable from SETUP entry through HOLD exit.
- **busy:** `busy = (state != IDLE)`.

## Timing
- **Reset values:**
  - `lcd_cs_n`=1, `lcd_wr_n`=1, `lcd_dc`=0, `lcd_data`=0, `busy`=0.
  - State IDLE, `cnt`=0, `last_pix`=0.
  - `fifo_rinc`=0.
  - `fifo_winc`, `cmd_ready` and `pix_ready` follow their combinational equations and are 0 when there are no valids.
- **Reset mid-operation:** asserting `rst` in any state forces the reset values immediately (asynchronous). No pop is issued. The FIFO shares `rst` and is cleared with it.
- **Write latency:** push occurs in the same cycle as the handshake. Accepted words appear at the FIFO head one cycle later.
- **LCD cycle length:** 1 + T_SETUP + T_WR + T_HOLD clocks per word, IDLE included. With defaults that is 5 clocks, with `lcd_wr_n` low for 2.
- **Back-to-back words:** one IDLE cycle with `lcd_cs_n`=1 always separates words.
- **FIFO timing:**
  - Pop in HOLD and push in the same cycle are both legal.
  - A word pushed into an empty FIFO is visible in IDLE the next cycle, so the first `lcd_cs_n` fall is 2 clocks after the push handshake.

## Test plan
- **Single command:** reset, then `cmd_valid`=1, `cmd_data`=0x2C for one cycle. Expect `cmd_ready`=1 and `fifo_wdata`=0x02C. On the LCD: `lcd_dc`=0, `lcd_data`=0x2C, `lcd_cs_n` low for 4 clocks, `lcd_wr_n` low clocks 2–3 of the SETUP/STROBE/HOLD window (`lcd_cs_n` low, after IDLE), one `fifo_rinc` pulse, then `busy`=0.
- **Round-robin:** `cmd_valid` and `pix_valid` held high for 4 cycles. Expect grants pix, cmd, pix, cmd, and LCD `lcd_dc` sequence 1,0,1,0.
- **Backpressure:** tie `fifo_wfull`=1 with both valids high. Expect `cmd_ready`=`pix_ready`=`fifo_winc`=0 and `last_pix` unchanged. Release and check the next grant follows round-robin order.
- **Empty drain:** `fifo_rempty`=1 throughout. Expect the FSM to stay in IDLE, `fifo_rinc` never asserted, and `lcd_cs_n`=1.
- **Timing parameters:** T_SETUP=2, T_WR=3, T_HOLD=2, with 3 queued pixels 0x11, 0x22, 0x33. Expect an 8-clock period per word, `lcd_wr_n` low for exactly 3 clocks, and data stable while `lcd_cs_n`=0.
- **Reset mid-strobe:** assert `rst` asynchronously while `lcd_wr_n`=0. Expect `lcd_wr_n`=`lcd_cs_n`=1 before the next edge, no `fifo_rinc`, and `busy`=0.
